// File: rtl/matrix_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matrix_host_ctrl
// Brief    : Host command front-end for the 5x5 int8 matrix ALU. Loads the
//            operand matrices, sequences EXEC against the ALU handshake and
//            returns one response word per accepted command.
// Revision : 1.0
// ============================================================================
module matrix_host_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAT_BITS       = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [31:0]         cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [15:0]         rsp_data,
    output logic [MAT_BITS-1:0] alu_a_flat,
    output logic [MAT_BITS-1:0] alu_b_flat,
    output logic [2:0]          alu_opcode,
    output logic [7:0]          alu_f,
    output logic [2:0]          alu_n,
    input  logic [MAT_BITS-1:0] alu_c_flat,
    input  logic                alu_overflow,
    input  logic                alu_done,
    output logic                busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam logic [2:0] c_CMD_LOAD_A = 3'b001;
    localparam logic [2:0] c_CMD_LOAD_B = 3'b010;
    localparam logic [2:0] c_CMD_EXEC   = 3'b011;
    localparam logic [2:0] c_CMD_READ_C = 3'b100;
    localparam logic [2:0] c_CMD_CLEAR  = 3'b101;

    localparam int               c_CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int               c_IDX_W    = $clog2(MAT_BITS);
    localparam logic [4:0]       c_IDX_MAX  = 5'd24;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [MAT_BITS-1:0] r_a;
    logic [MAT_BITS-1:0] r_b;
    logic [MAT_BITS-1:0] r_c;
    logic                r_ovf;
    logic [2:0]          r_alu_opcode;
    logic [7:0]          r_alu_f;
    logic [2:0]          r_alu_n;
    logic [15:0]         r_rsp_data;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_accept;
    logic [2:0]          w_cmd;
    logic [4:0]          w_idx;
    logic [7:0]          w_data;
    logic [2:0]          w_op;
    logic [2:0]          w_size;
    logic                w_idx_ok;
    logic [c_IDX_W-1:0]  w_base;
    logic                w_cnt_last;
    logic                w_unused;

    assign w_cmd      = cmd_data[2:0];
    assign w_idx      = cmd_data[7:3];
    assign w_data     = cmd_data[15:8];
    assign w_op       = cmd_data[18:16];
    assign w_size     = cmd_data[21:19];
    assign w_unused   = ^cmd_data[31:22];
    assign w_idx_ok   = (w_idx <= c_IDX_MAX);
    assign w_base     = c_IDX_W'(w_idx) << 3;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    function automatic logic [15:0] build_rsp(input logic timeout, input logic bad,
                                              input logic ovf, input logic [7:0] data);
        return {5'b0, timeout, bad, ovf, data};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; EXEC with op 000 never touches the ALU
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if ((w_cmd == c_CMD_EXEC) && (w_op != 3'b000)) begin
                        w_state_nxt = c_SETTLE;
                    end else begin
                        w_state_nxt = c_RESP;
                    end
                end
            end
            c_SETTLE: w_state_nxt = c_WAIT;
            c_WAIT: begin
                if (alu_done || w_cnt_last) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Handshake outputs; cmd_ready is also gated while reset is asserted
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        cmd_ready = rst_n && (r_state == c_IDLE);
        rsp_valid = (r_state == c_RESP);
        busy      = (r_state != c_IDLE);
    end

    // Operand, result and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_ovf        <= 1'b0;
            r_alu_opcode <= 3'b000;
            r_alu_f      <= 8'h00;
            r_alu_n      <= 3'd5;
            r_rsp_data   <= 16'h0000;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        case (w_cmd)
                            c_CMD_LOAD_A: begin
                                if (w_idx_ok) begin
                                    r_a[w_base +: 8] <= w_data;
                                end
                                r_rsp_data <= build_rsp(1'b0, !w_idx_ok, 1'b0, w_data);
                            end
                            c_CMD_LOAD_B: begin
                                if (w_idx_ok) begin
                                    r_b[w_base +: 8] <= w_data;
                                end
                                r_rsp_data <= build_rsp(1'b0, !w_idx_ok, 1'b0, w_data);
                            end
                            c_CMD_EXEC: begin
                                if (w_op == 3'b000) begin
                                    r_rsp_data <= build_rsp(1'b0, 1'b1, 1'b0, 8'h00);
                                end else begin
                                    r_alu_opcode <= w_op;
                                    r_alu_f      <= w_data;
                                    r_alu_n      <= w_size;
                                    r_cnt        <= '0;
                                end
                            end
                            c_CMD_READ_C: begin
                                r_rsp_data <= build_rsp(1'b0, !w_idx_ok, r_ovf,
                                                        w_idx_ok ? r_c[w_base +: 8] : 8'h00);
                            end
                            c_CMD_CLEAR: begin
                                r_a        <= '0;
                                r_b        <= '0;
                                r_c        <= '0;
                                r_ovf      <= 1'b0;
                                r_rsp_data <= 16'h0000;
                            end
                            default: begin
                                r_rsp_data <= 16'h0000;
                            end
                        endcase
                    end
                end
                c_WAIT: begin
                    // A late done on the final count still counts as completion
                    if (alu_done) begin
                        r_c          <= alu_c_flat;
                        r_ovf        <= alu_overflow;
                        r_alu_opcode <= 3'b000;
                        r_rsp_data   <= build_rsp(1'b0, 1'b0, alu_overflow, alu_c_flat[7:0]);
                    end else if (w_cnt_last) begin
                        r_alu_opcode <= 3'b000;
                        r_rsp_data   <= build_rsp(1'b1, 1'b0, 1'b0, 8'h00);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_data   = r_rsp_data;
    assign alu_a_flat = r_a;
    assign alu_b_flat = r_b;
    assign alu_opcode = r_alu_opcode;
    assign alu_f      = r_alu_f;
    assign alu_n      = r_alu_n;

endmodule
`default_nettype wire

// File: tb/tb_matrix_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_host_ctrl
// Brief    : Self-checking bench for matrix_host_ctrl with a behavioural ALU
//            stub and a command-level reference model.
// Revision : 1.0
// ============================================================================
module tb_matrix_host_ctrl;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int MAT_BITS       = 200;

    localparam logic [2:0] c_LA = 3'b001;
    localparam logic [2:0] c_LB = 3'b010;
    localparam logic [2:0] c_EX = 3'b011;
    localparam logic [2:0] c_RC = 3'b100;
    localparam logic [2:0] c_CL = 3'b101;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [31:0]         cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [15:0]         rsp_data;
    logic [MAT_BITS-1:0] alu_a_flat;
    logic [MAT_BITS-1:0] alu_b_flat;
    logic [2:0]          alu_opcode;
    logic [7:0]          alu_f;
    logic [2:0]          alu_n;
    logic [MAT_BITS-1:0] alu_c_flat;
    logic                alu_overflow;
    logic                alu_done;
    logic                busy;

    always #5 clk = ~clk;

    matrix_host_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAT_BITS      (MAT_BITS)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .alu_a_flat  (alu_a_flat),
        .alu_b_flat  (alu_b_flat),
        .alu_opcode  (alu_opcode),
        .alu_f       (alu_f),
        .alu_n       (alu_n),
        .alu_c_flat  (alu_c_flat),
        .alu_overflow(alu_overflow),
        .alu_done    (alu_done),
        .busy        (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  m_a [25];
    logic [7:0]  m_b [25];
    logic [7:0]  m_c [25];
    logic        m_ovf;
    logic [2:0]  m_opcode;
    logic [7:0]  m_f;
    logic [2:0]  m_n;
    logic [15:0] exp_rsp = 16'h0000;
    int          exp_busy = 0;
    logic        chk_en = 1'b0;
    int          stub_lat = 3;
    logic [15:0] last_rsp = 16'h0000;

    // Reference ALU: 001 add, 010 sub, 101 pass A, 110 scale by f; returns {ovf, C}
    function automatic logic [200:0] alu_ref(input logic [2:0] op, input logic [199:0] a,
                                             input logic [199:0] b, input logic [7:0] f);
        logic [199:0] c;
        logic         ov;
        int           x;
        c  = '0;
        ov = 1'b0;
        for (int k = 0; k < 25; k++) begin
            case (op)
                3'b001:  x = int'($signed(a[k*8 +: 8])) + int'($signed(b[k*8 +: 8]));
                3'b010:  x = int'($signed(a[k*8 +: 8])) - int'($signed(b[k*8 +: 8]));
                3'b101:  x = int'($signed(a[k*8 +: 8]));
                3'b110:  x = int'($signed(a[k*8 +: 8])) * int'($signed(f));
                default: x = 0;
            endcase
            if (x > 127 || x < -128) ov = 1'b1;
            c[k*8 +: 8] = x[7:0];
        end
        return {ov, c};
    endfunction

    function automatic logic [199:0] pack(input logic [7:0] m [25]);
        logic [199:0] v;
        for (int k = 0; k < 25; k++) v[k*8 +: 8] = m[k];
        return v;
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] cmd, input logic [4:0] idx,
                                       input logic [7:0] data, input logic [2:0] op,
                                       input logic [2:0] size);
        return {10'b0, size, op, data, idx, cmd};
    endfunction

    function automatic logic [15:0] mk_rsp(input logic to, input logic bad,
                                           input logic ovf, input logic [7:0] d);
        return {5'b0, to, bad, ovf, d};
    endfunction

    // ALU stub: done rises stub_lat cycles after the opcode appears; op 011 never finishes
    int            s_cnt = 0;
    logic [200:0]  w_stub;
    always @(posedge clk) s_cnt <= (alu_opcode == 3'b000) ? 0 : s_cnt + 1;
    always_comb w_stub = alu_ref(alu_opcode, alu_a_flat, alu_b_flat, alu_f);
    assign alu_c_flat   = w_stub[199:0];
    assign alu_overflow = w_stub[200];
    assign alu_done     = (alu_opcode != 3'b000) && (alu_opcode != 3'b011) && (s_cnt >= stub_lat);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 25; k++) begin
            m_a[k] = 8'h00;
            m_b[k] = 8'h00;
            m_c[k] = 8'h00;
        end
        m_ovf    = 1'b0;
        m_opcode = 3'b000;
        m_f      = 8'h00;
        m_n      = 3'd5;
    endtask

    // Command-level model: updates architectural state, predicts response and busy span
    task automatic model_accept(input logic [31:0] w);
        logic [2:0]   cmd;
        int           idx;
        logic [7:0]   data;
        logic [2:0]   op;
        logic [200:0] res;
        int           wait_c;
        cmd  = w[2:0];
        idx  = int'(w[7:3]);
        data = w[15:8];
        op   = w[18:16];
        exp_busy = 0;
        case (cmd)
            c_LA: begin
                if (idx < 25) m_a[idx] = data;
                exp_rsp = mk_rsp(1'b0, idx > 24, 1'b0, data);
            end
            c_LB: begin
                if (idx < 25) m_b[idx] = data;
                exp_rsp = mk_rsp(1'b0, idx > 24, 1'b0, data);
            end
            c_EX: begin
                if (op == 3'b000) begin
                    exp_rsp = mk_rsp(1'b0, 1'b1, 1'b0, 8'h00);
                end else begin
                    m_opcode = op;
                    m_f      = data;
                    m_n      = w[21:19];
                    wait_c   = (stub_lat < 1) ? 1 : stub_lat;
                    if (op == 3'b011 || wait_c > TIMEOUT_CYCLES) begin
                        exp_busy = 1 + TIMEOUT_CYCLES;
                        exp_rsp  = mk_rsp(1'b1, 1'b0, 1'b0, 8'h00);
                    end else begin
                        exp_busy = 1 + wait_c;
                        res = alu_ref(op, pack(m_a), pack(m_b), data);
                        for (int k = 0; k < 25; k++) m_c[k] = res[k*8 +: 8];
                        m_ovf   = res[200];
                        exp_rsp = mk_rsp(1'b0, 1'b0, m_ovf, m_c[0]);
                    end
                end
            end
            c_RC: begin
                if (idx < 25) exp_rsp = mk_rsp(1'b0, 1'b0, m_ovf, m_c[idx]);
                else          exp_rsp = mk_rsp(1'b0, 1'b1, m_ovf, 8'h00);
            end
            c_CL: begin
                for (int k = 0; k < 25; k++) begin
                    m_a[k] = 8'h00;
                    m_b[k] = 8'h00;
                    m_c[k] = 8'h00;
                end
                m_ovf   = 1'b0;
                exp_rsp = 16'h0000;
            end
            default: exp_rsp = 16'h0000;
        endcase
    endtask

    // Issue one command, check response timing, optionally stall the response
    task automatic run_cmd(input logic [31:0] w, input int hold, input logic [31:0] distract);
        int guard;
        int e;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_data  = w;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_accept(w);
        e = 1;
        while (!rsp_valid && e <= exp_busy + 3) begin
            chk("busy_while_waiting", busy, 1);
            @(posedge clk); #1;
            e++;
        end
        chk("rsp_latency", e, exp_busy + 1);
        m_opcode = 3'b000;
        if (!rsp_valid) return;
        last_rsp = rsp_data;
        for (int i = 0; i < hold; i++) begin
            if (distract != 32'h0) begin
                cmd_valid = 1'b1;
                cmd_data  = distract;
            end
            @(posedge clk); #1;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_rsp_data", rsp_data, exp_rsp);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("post_handshake_valid", rsp_valid, 0);
        chk("post_handshake_ready", cmd_ready, 1);
    endtask

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (alu_a_flat !== pack(m_a)) begin
                n_bad++;
                $display("FAIL alu_a_flat: got %h expected %h", alu_a_flat, pack(m_a));
            end
            n_cmp++;
            if (alu_b_flat !== pack(m_b)) begin
                n_bad++;
                $display("FAIL alu_b_flat: got %h expected %h", alu_b_flat, pack(m_b));
            end
            chk("alu_opcode", alu_opcode, m_opcode);
            chk("alu_f", alu_f, m_f);
            chk("alu_n", alu_n, m_n);
            if (rsp_valid) chk("rsp_data", rsp_data, exp_rsp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 32'h0;
        rsp_ready = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_opcode", alu_opcode, 0);
        chk("rst_f", alu_f, 0);
        chk("rst_n_out", alu_n, 5);
        chk("rst_a_zero", |alu_a_flat, 0);
        chk("rst_b_zero", |alu_b_flat, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_cmd_ready", cmd_ready, 1);
        chk_en = 1'b1;

        // Scalar multiply overflow
        stub_lat = 3;
        run_cmd(mk(c_LA, 5'd0, 8'h0E, 3'b000, 3'd0), 0, 32'h0);
        chk("t2_load_rsp", last_rsp, 16'h000E);
        run_cmd(mk(c_EX, 5'd0, 8'd10, 3'b110, 3'd5), 0, 32'h0);
        chk("t2_exec_rsp", last_rsp, 16'h018C);
        run_cmd(mk(c_RC, 5'd0, 8'h00, 3'b000, 3'd0), 0, 32'h0);
        chk("t2_read_c0", last_rsp, 16'h018C);

        // Matrix add, with done already high during SETTLE
        for (int k = 0; k < 3; k++)
            run_cmd(mk(c_LB, 5'(k), 8'(k + 1), 3'b000, 3'd0), 0, 32'h0);
        for (int k = 0; k < 25; k++)
            run_cmd(mk(c_LA, 5'(k), 8'h0E, 3'b000, 3'd0), 0, 32'h0);
        stub_lat = 0;
        run_cmd(mk(c_EX, 5'd0, 8'h00, 3'b001, 3'd5), 0, 32'h0);
        chk("t3_exec_rsp", last_rsp, 16'h000F);
        run_cmd(mk(c_RC, 5'd1, 8'h00, 3'b000, 3'd0), 0, 32'h0);
        chk("t3_read_c1", last_rsp, 16'h0010);
        run_cmd(mk(c_RC, 5'd3, 8'h00, 3'b000, 3'd0), 0, 32'h0);
        chk("t3_read_c3", last_rsp, 16'h000E);

        // Out-of-range load leaves A intact
        stub_lat = 2;
        run_cmd(mk(c_LA, 5'd25, 8'h55, 3'b000, 3'd0), 0, 32'h0);
        chk("t4_bad_load", last_rsp, 16'h0255);
        run_cmd(mk(c_EX, 5'd0, 8'h00, 3'b101, 3'd5), 0, 32'h0);
        run_cmd(mk(c_RC, 5'd24, 8'h00, 3'b000, 3'd0), 0, 32'h0);
        chk("t4_read_c24", last_rsp, 16'h000E);

        // Timeout preserves C
        run_cmd(mk(c_EX, 5'd0, 8'h07, 3'b011, 3'd3), 0, 32'h0);
        chk("t5_timeout_rsp", last_rsp, 16'h0400);
        run_cmd(mk(c_RC, 5'd0, 8'h00, 3'b000, 3'd0), 0, 32'h0);
        chk("t5_read_c0", last_rsp, 16'h000E);

        // Odd commands
        run_cmd(mk(3'b000, 5'd3, 8'h12, 3'b000, 3'd0), 0, 32'h0);
        run_cmd(mk(3'b111, 5'd3, 8'h12, 3'b001, 3'd0), 0, 32'h0);
        run_cmd(mk(c_EX, 5'd0, 8'h09, 3'b000, 3'd2), 0, 32'h0);
        chk("exec_op0_rsp", last_rsp, 16'h0200);
        run_cmd(mk(c_RC, 5'd30, 8'h00, 3'b000, 3'd0), 0, 32'h0);
        chk("read_bad_idx", last_rsp, 16'h0200);

        // Stalled response with a competing command held on the channel
        run_cmd(mk(c_RC, 5'd2, 8'h00, 3'b000, 3'd0), 10, mk(c_LA, 5'd5, 8'hAA, 3'b000, 3'd0));
        chk("t6_stalled_rsp", last_rsp, 16'h000E);

        run_cmd(mk(c_CL, 5'd0, 8'h00, 3'b000, 3'd0), 0, 32'h0);
        run_cmd(mk(c_RC, 5'd0, 8'h00, 3'b000, 3'd0), 0, 32'h0);
        chk("clear_read_c0", last_rsp, 16'h0000);

        // Reset while waiting on the ALU
        run_cmd(mk(c_LB, 5'd4, 8'h3C, 3'b000, 3'd0), 0, 32'h0);
        chk("pre_rst_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_data  = mk(c_EX, 5'd0, 8'h33, 3'b011, 3'd4);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        m_opcode  = 3'b011;
        m_f       = 8'h33;
        m_n       = 3'd4;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("mid_wait_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        chk("after_rst_busy", busy, 0);
        chk("after_rst_opcode", alu_opcode, 0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("after_rst_no_rsp", rsp_valid, 0);
        end
        run_cmd(mk(c_LA, 5'd7, 8'h21, 3'b000, 3'd0), 0, 32'h0);
        chk("after_rst_load", last_rsp, 16'h0021);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
